// File: rtl/tdc_hit_capture_if.sv
// Output stream of the TDC hit capture stage: head entry plus valid/ready handshake.
// The master drives the head entry and out_valid; the slave drives out_ready.
interface tdc_hit_capture_if #(
  parameter int CODE_W   = 32,
  parameter int COARSE_W = 16
);
  logic [CODE_W-1:0]   code_out;
  logic [COARSE_W-1:0] coarse_out;
  logic                code_err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output code_out,
    output coarse_out,
    output code_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  code_out,
    input  coarse_out,
    input  code_err,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/tdc_hit_capture.sv
// One-channel TDC capture: snapshots phase and coarse count on a hit edge, removes bubbles,
// flags non-ring codes and queues entries in a show-ahead FIFO (hit edge to out_valid: 3 edges).
module tdc_hit_capture #(
  parameter int CODE_W     = 32,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hit_in,
  input  logic [CODE_W-1:0] phase_in,
  output logic              overflow,
  tdc_hit_capture_if.master o_if
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [CODE_W-1:0]   code;
    logic [COARSE_W-1:0] coarse;
    logic                err;
  } entry_t;

  logic                r_hit;
  logic                r_hit_q;
  logic [CODE_W-1:0]   r_ph;
  logic [COARSE_W-1:0] r_coarse;
  logic [COARSE_W-1:0] r_coarse_s;
  logic                r_s1_vld;
  logic [CODE_W-1:0]   r_raw;
  logic [COARSE_W-1:0] r_coarse_lat;
  logic                r_s2_vld;
  entry_t              r_s2;
  entry_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  entry_t              r_hold;
  logic                r_ovf;

  logic                w_event;
  logic [CODE_W-1:0]   w_corr;
  logic [CODE_W-1:0]   w_rot;
  logic                w_err;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  entry_t              w_head;

  assign w_event = r_hit & ~r_hit_q & en;

  // Three-tap circular majority vote; tap 0 and tap CODE_W-1 are neighbours.
  for (genvar g = 0; g < CODE_W; g++) begin : g_maj
    localparam int LO = (g + CODE_W - 1) % CODE_W;
    localparam int HI = (g + 1) % CODE_W;
    assign w_corr[g] = (r_raw[LO] & r_raw[g]) | (r_raw[g] & r_raw[HI]) | (r_raw[LO] & r_raw[HI]);
  end

  // A single circular run of half-ones has exactly two 0/1 boundaries.
  assign w_rot = {w_corr[CODE_W-2:0], w_corr[CODE_W-1]};
  assign w_err = !(($countones(w_corr) == CODE_W / 2) && ($countones(w_corr ^ w_rot) == 2));

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && o_if.out_ready;
  assign w_push  = r_s2_vld && (!w_full || w_pop);
  assign w_head  = w_empty ? r_hold : r_mem[r_rd_ptr];

  assign o_if.out_valid  = !w_empty;
  assign o_if.code_out   = w_head.code;
  assign o_if.coarse_out = w_head.coarse;
  assign o_if.code_err   = w_head.err;
  assign overflow        = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit        <= 1'b0;
      r_hit_q      <= 1'b0;
      r_ph         <= '0;
      r_coarse     <= '0;
      r_coarse_s   <= '0;
      r_s1_vld     <= 1'b0;
      r_raw        <= '0;
      r_coarse_lat <= '0;
      r_s2_vld     <= 1'b0;
      r_s2         <= '0;
      r_mem        <= '{default: '0};
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_hold       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_hit      <= hit_in;
      r_hit_q    <= r_hit;
      r_ph       <= phase_in;
      // Coarse snapshot taken on the same edge as the phase taps.
      r_coarse_s <= r_coarse;
      if (en) r_coarse <= r_coarse + COARSE_W'(1);

      r_s1_vld <= w_event;
      if (w_event) begin
        r_raw        <= r_ph;
        r_coarse_lat <= r_coarse_s;
      end

      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2.code   <= w_corr;
        r_s2.coarse <= r_coarse_lat;
        r_s2.err    <= w_err;
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= r_s2;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_hold   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (r_s2_vld && w_full && !w_pop) r_ovf <= 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
